// File: rtl/alu_issue_ctrl_pkg.sv
// ISA constants and decode helpers shared by the ALU issue controller.
// Opcode/ext tables follow the 16-bit two-operand instruction format.
package alu_isa_pkg;

  localparam int ISA_WIDTH   = 16;
  localparam int ISA_CTL_LEN = 8;
  localparam int ISA_RADDR   = 4;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'b0000, OP_ANDI  = 4'b0001, OP_ORI   = 4'b0010, OP_XORI  = 4'b0011,
    OP_RSVD4 = 4'b0100, OP_ADDI  = 4'b0101, OP_ADDUI = 4'b0110, OP_ADDCI = 4'b0111,
    OP_SHIFT = 4'b1000, OP_SUBI  = 4'b1001, OP_RSVDA = 4'b1010, OP_CMPI  = 4'b1011,
    OP_BCOND = 4'b1100, OP_MOVI  = 4'b1101, OP_RSVDE = 4'b1110, OP_LUI   = 4'b1111
  } op_e;

  localparam logic [3:0] EXT_AND  = 4'b0001, EXT_OR   = 4'b0010, EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101, EXT_ADDU = 4'b0110, EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_SUB  = 4'b1001, EXT_SUBC = 4'b1010, EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101, EXT_MUL  = 4'b1110;

  localparam logic [3:0] EXT_LSHI_L  = 4'b0000, EXT_LSHI_R  = 4'b0001;
  localparam logic [3:0] EXT_ASHUI_L = 4'b0010, EXT_ASHUI_R = 4'b0011;
  localparam logic [3:0] EXT_LSH     = 4'b0100, EXT_ASHU    = 4'b0110;

  typedef enum logic [3:0] {
    C_EQ = 4'd0, C_NE = 4'd1, C_CS = 4'd2,  C_CC = 4'd3,  C_HI = 4'd4,  C_LS = 4'd5,
    C_GT = 4'd6, C_LE = 4'd7, C_FS = 4'd8,  C_FC = 4'd9,  C_LO = 4'd10, C_HS = 4'd11,
    C_LT = 4'd12, C_GE = 4'd13, C_UC = 4'd14, C_NV = 4'd15
  } cond_e;

  localparam int PSR_C = 0, PSR_L = 1, PSR_F = 2, PSR_Z = 3, PSR_N = 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  function automatic logic is_legal(input logic [ISA_WIDTH-1:0] ins);
    logic [3:0] ext;
    ext = ins[7:4];
    case (op_e'(ins[15:12]))
      OP_RTYPE: return ext inside {EXT_ADD, EXT_ADDU, EXT_ADDC, EXT_MUL, EXT_SUB, EXT_SUBC,
                                   EXT_CMP, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV};
      OP_SHIFT: return ext inside {EXT_LSHI_L, EXT_LSHI_R, EXT_ASHUI_L, EXT_ASHUI_R,
                                   EXT_LSH, EXT_ASHU};
      OP_RSVD4, OP_RSVDA, OP_RSVDE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic sets_psr(input logic [ISA_WIDTH-1:0] ins);
    op_e op;
    op = op_e'(ins[15:12]);
    if (op == OP_RTYPE)
      return ins[7:4] inside {EXT_ADD, EXT_ADDU, EXT_ADDC, EXT_MUL, EXT_SUB, EXT_SUBC, EXT_CMP};
    return op inside {OP_ADDI, OP_ADDUI, OP_SUBI, OP_CMPI};
  endfunction

  function automatic logic writes_rf(input logic [ISA_WIDTH-1:0] ins);
    op_e op;
    op = op_e'(ins[15:12]);
    if (!is_legal(ins) || op == OP_BCOND || op == OP_CMPI) return 1'b0;
    return !(op == OP_RTYPE && ins[7:4] == EXT_CMP);
  endfunction

  function automatic logic [ISA_CTL_LEN-1:0] alu_ctl_of(input logic [ISA_WIDTH-1:0] ins);
    if (!is_legal(ins)) return '0;
    case (op_e'(ins[15:12]))
      OP_RTYPE, OP_SHIFT: return {ins[15:12], ins[7:4]};
      OP_BCOND:           return '0;
      default:            return {ins[15:12], 4'b0000};
    endcase
  endfunction

  function automatic logic [ISA_WIDTH-1:0] alu_src_of(input logic [ISA_WIDTH-1:0] ins,
                                                      input logic [ISA_WIDTH-1:0] rsrc);
    if (!is_legal(ins)) return '0;
    case (op_e'(ins[15:12]))
      OP_RTYPE: return rsrc;
      OP_SHIFT: return (ins[7:4] inside {EXT_LSH, EXT_ASHU}) ? rsrc : {12'h000, ins[3:0]};
      OP_ADDI, OP_SUBI, OP_CMPI, OP_ADDCI: return {{8{ins[7]}}, ins[7:0]};
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDUI, OP_MOVI, OP_LUI: return {8'h00, ins[7:0]};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the issue controller and its instruction source, register file and ALU.
// slave = controller side, master = environment side.
interface alu_issue_if
  import alu_isa_pkg::*;
#(
  parameter int WIDTH   = ISA_WIDTH,
  parameter int CTL_LEN = ISA_CTL_LEN,
  parameter int RADDR   = ISA_RADDR
);
  logic               instr_valid;
  logic               instr_ready;
  logic [WIDTH-1:0]   instr;
  logic [RADDR-1:0]   rf_raddr_src;
  logic [RADDR-1:0]   rf_raddr_dst;
  logic [WIDTH-1:0]   rf_rdata_src;
  logic [WIDTH-1:0]   rf_rdata_dst;
  logic [CTL_LEN-1:0] alu_ctl;
  logic [WIDTH-1:0]   alu_src;
  logic [WIDTH-1:0]   alu_dst;
  logic [WIDTH-1:0]   alu_result;
  logic [4:0]         alu_flags;
  logic               rf_we;
  logic [RADDR-1:0]   rf_waddr;
  logic [WIDTH-1:0]   rf_wdata;
  logic [4:0]         psr;
  logic               branch_valid;
  logic               branch_taken;
  logic [WIDTH-1:0]   branch_disp;
  logic               illegal;

  modport slave (
    input  instr_valid, instr, rf_rdata_src, rf_rdata_dst, alu_result, alu_flags,
    output instr_ready, rf_raddr_src, rf_raddr_dst, alu_ctl, alu_src, alu_dst,
           rf_we, rf_waddr, rf_wdata, psr, branch_valid, branch_taken, branch_disp, illegal
  );

  modport master (
    output instr_valid, instr, rf_rdata_src, rf_rdata_dst, alu_result, alu_flags,
    input  instr_ready, rf_raddr_src, rf_raddr_dst, alu_ctl, alu_src, alu_dst,
           rf_we, rf_waddr, rf_wdata, psr, branch_valid, branch_taken, branch_disp, illegal
  );
endinterface

// File: rtl/alu_cond_eval.sv
// Branch condition evaluation of a 4-bit condition code against the PSR {N,Z,F,L,C}.
module alu_cond_eval
  import alu_isa_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] psr,
  output logic       taken
);
  logic n, z, f, l, c;

  assign n = psr[PSR_N];
  assign z = psr[PSR_Z];
  assign f = psr[PSR_F];
  assign l = psr[PSR_L];
  assign c = psr[PSR_C];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      C_EQ: taken = z;
      C_NE: taken = !z;
      C_CS: taken = c;
      C_CC: taken = !c;
      C_HI: taken = l;
      C_LS: taken = !l;
      C_GT: taken = n;
      C_LE: taken = !n;
      C_FS: taken = f;
      C_FC: taken = !f;
      C_LO: taken = !l && !z;
      C_HS: taken = l || z;
      C_LT: taken = !n && !z;
      C_GE: taken = n || z;
      C_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue controller: accepts one instruction, reads the register file,
// drives the ALU, then writes back result/PSR or resolves a branch.
//   state  | meaning
//   S_IDLE | ready for an instruction word
//   S_READ | register-file addresses presented
//   S_EXEC | ALU driven, result and flags captured at the end
//   S_WB   | writeback / branch / illegal pulses
module alu_issue_ctrl
  import alu_isa_pkg::*;
#(
  parameter int WIDTH   = ISA_WIDTH,
  parameter int CTL_LEN = ISA_CTL_LEN,
  parameter int RADDR   = ISA_RADDR
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   instr_q, result_q;
  logic [4:0]         psr_q;
  logic [CTL_LEN-1:0] ctl_w;
  logic               accept, legal, is_branch, cond_taken;

  assign accept    = bus.instr_valid && (state_q == S_IDLE);
  assign legal     = is_legal(instr_q);
  assign is_branch = (instr_q[15:12] == OP_BCOND);
  assign ctl_w     = alu_ctl_of(instr_q);
  assign bus.psr   = psr_q;

  alu_cond_eval u_cond (
    .cond  (instr_q[11:8]),
    .psr   (psr_q),
    .taken (cond_taken)
  );

  // PSR is loaded on the EXEC->WB edge so it is already visible throughout WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      psr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= bus.instr;
      if (state_q == S_EXEC) begin
        result_q <= bus.alu_result;
        if (sets_psr(instr_q)) psr_q <= bus.alu_flags;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.instr_ready  = 1'b0;
    bus.rf_raddr_dst = instr_q[8 +: RADDR];
    bus.rf_raddr_src = instr_q[0 +: RADDR];
    bus.alu_ctl      = '0;
    bus.alu_src      = '0;
    bus.alu_dst      = '0;
    bus.rf_we        = 1'b0;
    bus.rf_waddr     = '0;
    bus.rf_wdata     = '0;
    bus.branch_valid = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_disp  = '0;
    bus.illegal      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        state_d     = S_WB;
        bus.alu_ctl = ctl_w;
        bus.alu_src = alu_src_of(instr_q, bus.rf_rdata_src);
        bus.alu_dst = bus.rf_rdata_dst;
      end
      S_WB: begin
        state_d          = S_IDLE;
        bus.rf_we        = writes_rf(instr_q);
        bus.rf_waddr     = instr_q[8 +: RADDR];
        bus.rf_wdata     = result_q;
        bus.branch_valid = is_branch;
        bus.branch_taken = is_branch && cond_taken;
        bus.branch_disp  = is_branch ? {{(WIDTH-8){instr_q[7]}}, instr_q[7:0]} : '0;
        bus.illegal      = !legal;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed vector bench for alu_issue_ctrl with a small register-file model and a scripted ALU.
module tb_alu_issue_ctrl;
  import alu_isa_pkg::*;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] res;
    logic [4:0]  flags;
    logic        chk_alu;
    logic [7:0]  ctl;
    logic [15:0] src;
    logic [15:0] dst;
    logic        we;
    logic [15:0] wdata;
    logic [4:0]  psr;
    logic        bv;
    logic        bt;
    logic [15:0] disp;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic alu_pass = 1'b0;
  logic [15:0] alu_res_v = 16'h0;
  logic [4:0]  alu_flags_v = 5'h0;
  logic [15:0] rf [16] = '{16'h0000, 16'h0005, 16'h1234, 16'h0001, 16'h0000, 16'h7FFF,
                           16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                           16'h0000, 16'h0000, 16'h0000, 16'h0000};
  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  alu_issue_if bus ();

  alu_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.alu_result = alu_pass ? bus.alu_src : alu_res_v;
  assign bus.alu_flags  = alu_flags_v;

  always @(posedge clk) begin
    bus.rf_rdata_src <= rf[bus.rf_raddr_src];
    bus.rf_rdata_dst <= rf[bus.rf_raddr_dst];
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] instr, input logic [15:0] res,
                              input logic [4:0] flags, input logic chk_alu,
                              input logic [7:0] ctl, input logic [15:0] src,
                              input logic [15:0] dst, input logic we,
                              input logic [15:0] wdata, input logic [4:0] psr,
                              input logic bv, input logic bt,
                              input logic [15:0] disp, input logic ill);
    vec_t v;
    v.instr = instr; v.res = res; v.flags = flags; v.chk_alu = chk_alu;
    v.ctl = ctl; v.src = src; v.dst = dst; v.we = we; v.wdata = wdata;
    v.psr = psr; v.bv = bv; v.bt = bt; v.disp = disp; v.ill = ill;
    return v;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({name, ".idle"}, {31'd0, bus.instr_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    wait_idle(p);
    bus.instr = v.instr;
    bus.instr_valid = 1'b1;
    alu_res_v = v.res;
    alu_flags_v = v.flags;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    @(negedge clk);
    chk({p, ".ready_read"}, {31'd0, bus.instr_ready}, 32'd0);
    @(negedge clk);
    chk({p, ".ready_exec"}, {31'd0, bus.instr_ready}, 32'd0);
    if (v.chk_alu) begin
      chk({p, ".alu_ctl"}, {24'd0, bus.alu_ctl}, {24'd0, v.ctl});
      chk({p, ".alu_src"}, {16'd0, bus.alu_src}, {16'd0, v.src});
      chk({p, ".alu_dst"}, {16'd0, bus.alu_dst}, {16'd0, v.dst});
    end
    @(negedge clk);
    chk({p, ".ready_wb"}, {31'd0, bus.instr_ready}, 32'd0);
    chk({p, ".rf_we"}, {31'd0, bus.rf_we}, {31'd0, v.we});
    if (v.we) begin
      chk({p, ".rf_waddr"}, {28'd0, bus.rf_waddr}, {28'd0, v.instr[11:8]});
      chk({p, ".rf_wdata"}, {16'd0, bus.rf_wdata}, {16'd0, v.wdata});
    end
    chk({p, ".psr"}, {27'd0, bus.psr}, {27'd0, v.psr});
    chk({p, ".branch_valid"}, {31'd0, bus.branch_valid}, {31'd0, v.bv});
    if (v.bv) begin
      chk({p, ".branch_taken"}, {31'd0, bus.branch_taken}, {31'd0, v.bt});
      chk({p, ".branch_disp"}, {16'd0, bus.branch_disp}, {16'd0, v.disp});
    end
    chk({p, ".illegal"}, {31'd0, bus.illegal}, {31'd0, v.ill});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;

    // instr, res, flags, chk_alu, ctl, src, dst, we, wdata, psr, bv, bt, disp, ill
    vecs.push_back(mk(16'h0355, 16'h8000, 5'h14, 1, 8'h05, 16'h7FFF, 16'h0001, 1, 16'h8000, 5'h14, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'h52FF, 16'h1233, 5'h01, 1, 8'h50, 16'hFFFF, 16'h1234, 1, 16'h1233, 5'h01, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'h12FF, 16'h0033, 5'h1F, 1, 8'h10, 16'h00FF, 16'h1233, 1, 16'h0033, 5'h01, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'hB105, 16'h0000, 5'h08, 1, 8'hB0, 16'h0005, 16'h0005, 0, 16'h0000, 5'h08, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'hC0F0, 16'hDEAD, 5'h1F, 1, 8'h00, 16'h0000, 16'h0000, 0, 16'h0000, 5'h08, 1, 1, 16'hFFF0, 0));
    vecs.push_back(mk(16'hC1F0, 16'hDEAD, 5'h1F, 1, 8'h00, 16'h0000, 16'h0005, 0, 16'h0000, 5'h08, 1, 0, 16'hFFF0, 0));
    vecs.push_back(mk(16'hCFF0, 16'hDEAD, 5'h1F, 1, 8'h00, 16'h0000, 16'h0000, 0, 16'h0000, 5'h08, 1, 0, 16'hFFF0, 0));
    vecs.push_back(mk(16'h4123, 16'hDEAD, 5'h1F, 0, 8'h00, 16'h0000, 16'h0000, 0, 16'h0000, 5'h08, 0, 0, 16'h0000, 1));
    vecs.push_back(mk(16'h0201, 16'hDEAD, 5'h1F, 0, 8'h00, 16'h0000, 16'h0000, 0, 16'h0000, 5'h08, 0, 0, 16'h0000, 1));
    vecs.push_back(mk(16'h8214, 16'h0019, 5'h1F, 1, 8'h81, 16'h0004, 16'h0033, 1, 16'h0019, 5'h08, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'h8341, 16'h0001, 5'h1F, 1, 8'h84, 16'h0005, 16'h8000, 1, 16'h0001, 5'h08, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'h0391, 16'hFFFC, 5'h10, 1, 8'h09, 16'h0005, 16'h0001, 1, 16'hFFFC, 5'h10, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'hC607, 16'hDEAD, 5'h1F, 1, 8'h00, 16'h0000, 16'h0000, 0, 16'h0000, 5'h10, 1, 1, 16'h0007, 0));
    vecs.push_back(mk(16'hC50A, 16'hDEAD, 5'h1F, 1, 8'h00, 16'h0000, 16'h7FFF, 0, 16'h0000, 5'h10, 1, 1, 16'h000A, 0));
    vecs.push_back(mk(16'hCC80, 16'hDEAD, 5'h1F, 1, 8'h00, 16'h0000, 16'h0000, 0, 16'h0000, 5'h10, 1, 0, 16'hFF80, 0));
    vecs.push_back(mk(16'h8F57, 16'hDEAD, 5'h1F, 0, 8'h00, 16'h0000, 16'h0000, 0, 16'h0000, 5'h10, 0, 0, 16'h0000, 1));
    vecs.push_back(mk(16'hD47F, 16'h007F, 5'h1F, 1, 8'hD0, 16'h007F, 16'h0000, 1, 16'h007F, 5'h10, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'h6AFF, 16'h00FF, 5'h02, 1, 8'h60, 16'h00FF, 16'h0000, 1, 16'h00FF, 5'h02, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(16'hCB00, 16'hDEAD, 5'h1F, 1, 8'h00, 16'h0000, 16'h0000, 0, 16'h0000, 5'h02, 1, 1, 16'h0000, 0));

    // Reset held two cycles, then state checked in the first cycle out of reset.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst.psr", {27'd0, bus.psr}, 32'd0);
    chk("rst.rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst.illegal", {31'd0, bus.illegal}, 32'd0);
    chk("rst.branch_valid", {31'd0, bus.branch_valid}, 32'd0);
    chk("rst.alu_ctl", {24'd0, bus.alu_ctl}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset arriving in EXEC of an ADD: no writeback, PSR cleared, IDLE next cycle.
    wait_idle("rexec");
    bus.instr = 16'h0355;
    bus.instr_valid = 1'b1;
    alu_res_v = 16'h1234;
    alu_flags_v = 5'h1F;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rexec.in_exec_ctl", {24'd0, bus.alu_ctl}, 32'h05);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rexec.instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rexec.psr", {27'd0, bus.psr}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rexec.rf_we_c%0d", c), {31'd0, bus.rf_we}, 32'd0);
      chk($sformatf("rexec.illegal_c%0d", c), {31'd0, bus.illegal}, 32'd0);
      @(negedge clk);
    end

    // instr_valid held high while busy: second word only taken at the next IDLE.
    alu_pass = 1'b1;
    alu_flags_v = 5'h1F;
    wait_idle("hold");
    bus.instr = 16'hD611;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr = 16'hD722;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("hold.ready_c%0d", c), {31'd0, bus.instr_ready},
          (c == 4 || c == 8) ? 32'd1 : 32'd0);
      chk($sformatf("hold.rf_we_c%0d", c), {31'd0, bus.rf_we},
          (c == 3 || c == 7) ? 32'd1 : 32'd0);
      if (c == 3 || c == 7) begin
        chk($sformatf("hold.rf_waddr_c%0d", c), {28'd0, bus.rf_waddr}, (c == 3) ? 32'd6 : 32'd7);
        chk($sformatf("hold.rf_wdata_c%0d", c), {16'd0, bus.rf_wdata},
            (c == 3) ? 32'h0011 : 32'h0022);
      end
      if (c == 5) bus.instr_valid = 1'b0;
    end
    chk("hold.psr", {27'd0, bus.psr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
